// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the push-button / switch input blocks.
package debounce_pkg;

   // 1 ms of stability at 50 MHz
   localparam int DEB_STABLE_DEFAULT = 50000;
   // Long-press detection disabled
   localparam int DEB_LONG_DEFAULT   = 0;

   // Ceiling log2; deb_clog2(1) = 0
   function automatic int deb_clog2(input int value);
      int width;
      width = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         width = width + 1;
      end
      return width;
   endfunction

   // Width of a counter that must hold the values 0..max_count (never below 1)
   function automatic int deb_cnt_width(input int max_count);
      int width;
      width = deb_clog2(max_count + 1);
      return (width < 1) ? 1 : width;
   endfunction

   // Pin level of a released button: high for active-low wiring, low otherwise
   function automatic logic deb_idle_level(input bit active_low);
      return active_low ? 1'b1 : 1'b0;
   endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: two-flop synchroniser, restartable stability counter,
// debounced level with registered rise/fall pulses and an optional hold
// counter producing a single long-press pulse.
module debounce_ch
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEB_STABLE_DEFAULT,
   parameter int LONG_CYCLES   = DEB_LONG_DEFAULT,
   parameter int ACTIVE_LOW    = 0
) (
   input  logic clk,
   input  logic rstn,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_rise,
   output logic btn_fall,
   output logic btn_long
);

   localparam logic IDLE_PIN = deb_idle_level(ACTIVE_LOW != 0);
   localparam int   SW       = deb_cnt_width(STABLE_CYCLES);
   localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);

   logic          sync1_reg;
   logic          sync2_reg;
   logic          s;
   logic [SW-1:0] stab_cnt_reg;
   logic [SW-1:0] stab_cnt_next;
   logic          level_reg;
   logic          level_next;
   logic          rise_reg;
   logic          fall_reg;
   logic          flip;

   // Synchroniser; resets to the released-pin level so release never looks like a press
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync1_reg <= IDLE_PIN;
         sync2_reg <= IDLE_PIN;
      end else begin
         sync1_reg <= btn_in;
         sync2_reg <= sync1_reg;
      end
   end

   assign s    = (ACTIVE_LOW != 0) ? ~sync2_reg : sync2_reg;
   assign flip = (s != level_reg) && (stab_cnt_reg == STABLE_LAST);

   // Next stability count and level: any agreement with the level restarts the count
   always_comb begin
      stab_cnt_next = stab_cnt_reg;
      level_next    = level_reg;
      if (s == level_reg) begin
         stab_cnt_next = '0;
      end else if (flip) begin
         stab_cnt_next = '0;
         level_next    = s;
      end else begin
         stab_cnt_next = stab_cnt_reg + 1'b1;
      end
   end

   // Level, count and edge-pulse registers; pulses coincide with the level change
   always_ff @(posedge clk) begin
      if (!rstn) begin
         stab_cnt_reg <= '0;
         level_reg    <= 1'b0;
         rise_reg     <= 1'b0;
         fall_reg     <= 1'b0;
      end else begin
         stab_cnt_reg <= stab_cnt_next;
         level_reg    <= level_next;
         rise_reg     <= flip & s;
         fall_reg     <= flip & ~s;
      end
   end

   assign btn_level = level_reg;
   assign btn_rise  = rise_reg;
   assign btn_fall  = fall_reg;

   generate
      if (LONG_CYCLES > 0) begin : g_long
         localparam int HW = deb_cnt_width(LONG_CYCLES);
         localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
         localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYCLES);

         logic [HW-1:0] hold_cnt_reg;
         logic          long_reg;

         // Hold counter: cleared by a rise, counts while pressed, saturates after one pulse;
         // a release landing on the final count suppresses the pulse
         always_ff @(posedge clk) begin
            if (!rstn) begin
               hold_cnt_reg <= '0;
               long_reg     <= 1'b0;
            end else begin
               long_reg <= 1'b0;
               if (flip && s) begin
                  hold_cnt_reg <= '0;
               end else if (level_reg && (hold_cnt_reg != HOLD_SAT)) begin
                  hold_cnt_reg <= hold_cnt_reg + 1'b1;
                  if ((hold_cnt_reg == HOLD_LAST) && !flip) begin
                     long_reg <= 1'b1;
                  end
               end
            end
         end

         assign btn_long = long_reg;
      end else begin : g_no_long
         assign btn_long = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer: independent debounce_ch instances sharing one clock/reset.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int N_CH          = 4,
   parameter int STABLE_CYCLES = DEB_STABLE_DEFAULT,
   parameter int LONG_CYCLES   = DEB_LONG_DEFAULT,
   parameter int ACTIVE_LOW    = 0
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] btn_rise,
   output logic [N_CH-1:0] btn_fall,
   output logic [N_CH-1:0] btn_long
);

   // Reject illegal parameterisations at elaboration time
   generate
      if (N_CH < 1) begin : g_bad_n_ch
         $error("debounce_multi: N_CH must be >= 1");
      end
      if (STABLE_CYCLES < 1) begin : g_bad_stable
         $error("debounce_multi: STABLE_CYCLES must be >= 1");
      end
      if (LONG_CYCLES < 0) begin : g_bad_long
         $error("debounce_multi: LONG_CYCLES must be >= 0");
      end
      if ((ACTIVE_LOW != 0) && (ACTIVE_LOW != 1)) begin : g_bad_active_low
         $error("debounce_multi: ACTIVE_LOW must be 0 or 1");
      end
   endgenerate

   // One fully independent channel per input bit
   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         debounce_ch #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .ACTIVE_LOW    (ACTIVE_LOW)
         ) u_ch (
            .clk       (clk),
            .rstn      (rstn),
            .btn_in    (btn_in[gi]),
            .btn_level (btn_level[gi]),
            .btn_rise  (btn_rise[gi]),
            .btn_fall  (btn_fall[gi]),
            .btn_long  (btn_long[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: an active-high and an active-low instance
// (the latter fed the inverted pins) are both checked against one reference model.
module tb_debounce_multi;

   localparam int N    = 4;
   localparam int S    = 4;
   localparam int L    = 16;
   localparam int MAXE = 4096;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic [N-1:0] btn_in = '0;
   logic [N-1:0] btn_in_n;

   logic [N-1:0] lvl_h, rise_h, fall_h, long_h;
   logic [N-1:0] lvl_l, rise_l, fall_l, long_l;

   assign btn_in_n = ~btn_in;

   debounce_multi #(.N_CH(N), .STABLE_CYCLES(S), .LONG_CYCLES(L), .ACTIVE_LOW(0)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .btn_in    (btn_in),
      .btn_level (lvl_h),
      .btn_rise  (rise_h),
      .btn_fall  (fall_h),
      .btn_long  (long_h)
   );

   debounce_multi #(.N_CH(N), .STABLE_CYCLES(S), .LONG_CYCLES(L), .ACTIVE_LOW(1)) dut_al (
      .clk       (clk),
      .rstn      (rstn),
      .btn_in    (btn_in_n),
      .btn_level (lvl_l),
      .btn_rise  (rise_l),
      .btn_fall  (fall_l),
      .btn_long  (long_l)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0]  edge_id;
      logic         rst_v;
      logic [N-1:0] pins;
      logic [N-1:0] lvl;
      logic [N-1:0] rise;
      logic [N-1:0] fall;
      logic [N-1:0] lng;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   int checks = 0;
   int fails  = 0;

   // Reference model state: logical pin value sampled at every edge, current level,
   // edge number of the most recent rise per channel.
   logic [N-1:0] hist [0:MAXE-1];
   logic [N-1:0] m_level = '0;
   int           last_rise [N];
   int           edge_no = 0;

   task automatic chk(input string name, input logic [15:0] eid,
                      input logic [N*4-1:0] act, input logic [N*4-1:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s edge %0d: got lvl/rise/fall/long=%b required %b", name, eid, act, req);
      end
   endtask

   // Drive one cycle of stimulus and push what the outputs must be after the next edge.
   // Model rules: a pin sample reaches the debouncer two edges later; the level flips at
   // edge t when the samples of edges t-S-1..t-2 all differ from it; long pulses when
   // the level is still 1 exactly L edges after its rise. Reset clears the last two
   // samples (the synchroniser contents) and the level.
   task automatic step(input logic r, input logic [N-1:0] b);
      exp_t e;
      logic flip;
      @(negedge clk);
      rstn   = r;
      btn_in = b;
      e = '0;
      e.edge_id = 16'(edge_no);
      e.rst_v   = r;
      e.pins    = b;
      if (!r) begin
         hist[edge_no] = '0;
         if (edge_no > 0) hist[edge_no-1] = '0;
         m_level = '0;
         for (int c = 0; c < N; c++) last_rise[c] = -100000;
      end else begin
         hist[edge_no] = b;
         for (int c = 0; c < N; c++) begin
            flip = 1'b0;
            if (edge_no >= S + 1) begin
               flip = 1'b1;
               for (int k = edge_no - S - 1; k <= edge_no - 2; k++) begin
                  if (hist[k][c] == m_level[c]) flip = 1'b0;
               end
            end
            if (flip) begin
               e.rise[c] = ~m_level[c];
               e.fall[c] = m_level[c];
               m_level[c] = ~m_level[c];
               if (m_level[c]) last_rise[c] = edge_no;
            end
            e.lng[c] = m_level[c] && ((edge_no - last_rise[c]) == L);
         end
      end
      e.lvl = m_level;
      exp_q.push_back(e);
      edge_no++;
   endtask

   task automatic hold(input logic r, input logic [N-1:0] b, input int n);
      for (int i = 0; i < n; i++) step(r, b);
   endtask

   // Monitor: one comparison per instance for every edge that has an expectation queued
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         $display("edge %0d rstn=%b pins=%b exp lvl=%b rise=%b fall=%b long=%b | got %b %b %b %b",
                  mon_e.edge_id, mon_e.rst_v, mon_e.pins, mon_e.lvl, mon_e.rise, mon_e.fall,
                  mon_e.lng, lvl_h, rise_h, fall_h, long_h);
         chk("active_high", mon_e.edge_id, {lvl_h, rise_h, fall_h, long_h},
             {mon_e.lvl, mon_e.rise, mon_e.fall, mon_e.lng});
         chk("active_low", mon_e.edge_id, {lvl_l, rise_l, fall_l, long_l},
             {mon_e.lvl, mon_e.rise, mon_e.fall, mon_e.lng});
      end
   end

   int           remain [N];
   logic [N-1:0] rnd_pins;

   initial begin
      for (int k = 0; k < MAXE; k++) hist[k] = '0;
      for (int c = 0; c < N; c++) last_rise[c] = -100000;

      // Reset with all pins pressed, then release: all four rise together
      hold(1'b0, 4'b1111, 3);
      hold(1'b1, 4'b1111, 10);
      hold(1'b1, 4'b0000, 10);

      // Clean press on ch0
      hold(1'b1, 4'b0001, 10);
      hold(1'b1, 4'b0000, 8);

      // Bouncing ch1, then held
      for (int r = 0; r < 5; r++) begin
         hold(1'b1, 4'b0010, 3);
         hold(1'b1, 4'b0000, 1);
      end
      hold(1'b1, 4'b0010, 10);
      hold(1'b1, 4'b0000, 8);

      // Long press ch2 and release
      hold(1'b1, 4'b0100, 30);
      hold(1'b1, 4'b0000, 25);

      // Short press ch3
      hold(1'b1, 4'b1000, 15);
      hold(1'b1, 4'b0000, 25);

      // Reset in the middle of a count
      hold(1'b1, 4'b0001, 3);
      hold(1'b0, 4'b0001, 1);
      hold(1'b1, 4'b0001, 10);
      hold(1'b1, 4'b0000, 8);

      // Randomised bouncy traffic on all channels with rare resets
      for (int c = 0; c < N; c++) remain[c] = 1;
      rnd_pins = '0;
      for (int t = 0; t < 1500; t++) begin
         for (int c = 0; c < N; c++) begin
            remain[c]--;
            if (remain[c] <= 0) begin
               rnd_pins[c] = ~rnd_pins[c];
               remain[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 30))
                                                        : int'($urandom_range(1, 6));
            end
         end
         step(($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1, rnd_pins);
      end
      hold(1'b1, 4'b0000, 30);

      // Drain: every queued expectation must have been consumed by the monitor
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d entries left required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
